// File: rtl/parity_serializer_pkg.sv
// Shared definitions for the parity serializer: FSM state encoding and
// counter-width helpers used to size the baud and bit counters.
package parity_serializer_pkg;

    // Frame sequencer states; encoding matches the register map seen by debug tools.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    localparam int unsigned DefaultDataWidth  = 8;
    localparam int unsigned DefaultClksPerBit = 16;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parity_serializer_if.sv
// Upstream word handshake plus serial-line status for the parity serializer.
// master: the word producer / line observer. slave: the serializer itself.
interface parity_serializer_if
    import parity_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
);

    logic [DATA_WIDTH-1:0] di;
    logic                  di_valid;
    logic                  di_ready;
    logic                  tx;
    logic                  busy;

    modport master (
        output di,
        output di_valid,
        input  di_ready,
        input  tx,
        input  busy
    );

    modport slave (
        input  di,
        input  di_valid,
        output di_ready,
        output tx,
        output busy
    );

endinterface

// File: rtl/parity_serializer_gen.sv
// Even-parity generator: output is 1 when the word holds an odd number of
// ones, so word plus parity bit always carries an even count.
module parity_serializer_gen #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  parity
);

    assign parity = ^data;

endmodule

// File: rtl/parity_serializer.sv
// Parallel-to-serial framer: start bit, data LSB-first, parity bit, stop bit,
// each held CLKS_PER_BIT cycles. The line output is registered.
// Build option: define PARITY_SERIALIZER_ODD_EN for odd parity (default even).
module parity_serializer
    import parity_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic           clk,
    input  logic           rst,
    parity_serializer_if.slave bus
);

    localparam int unsigned BaudW = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BitW  = cnt_width(DATA_WIDTH);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;

    logic gen_parity;
    logic frame_parity;
    logic handshake;
    logic baud_done;

    parity_serializer_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_gen (
        .data  (bus.di),
        .parity(gen_parity)
    );

`ifdef PARITY_SERIALIZER_ODD_EN
    assign frame_parity = ~gen_parity;
`else
    assign frame_parity = gen_parity;
`endif

    // Ready is masked by rst so nothing is offered while reset is held.
    assign bus.di_ready = (state_q == StIdle) && !rst;
    assign bus.busy     = (state_q != StIdle);
    assign bus.tx       = tx_q;

    assign handshake = bus.di_valid && bus.di_ready;
    assign baud_done = (baud_q == BaudLast);

    // Next-state logic for the frame sequencer, counters, shifter and line.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = 1'b1;

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                if (handshake) begin
                    shift_d  = bus.di;
                    parity_d = frame_parity;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_done) begin
                    if (bit_q == BitLast) begin
                        bit_d   = '0;
                        state_d = StParity;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (baud_done) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (baud_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q != StIdle) begin
            baud_d = baud_done ? '0 : baud_q + 1'b1;
        end

        // Line level is chosen from the upcoming state so tx changes on the
        // same edge as the state it belongs to.
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State register; reset aborts any frame immediately and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_parity_serializer.sv
// Self-checking bench for parity_serializer (DATA_WIDTH=8, CLKS_PER_BIT=4).
// Expected line waveforms come from a frame model built from the data word.
module tb_parity_serializer;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 3) * CPB;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used to measure start-bit spacing.
    always @(posedge clk) cyc <= cyc + 1;

    parity_serializer_if #(.DATA_WIDTH(DW)) bus ();

    parity_serializer #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Parity bit chosen so the total count of ones in data+parity is even
    // (or odd when the odd-parity build option is on).
    function automatic logic model_parity(input logic [DW-1:0] d);
        int ones;
        ones = $countones(d);
`ifdef PARITY_SERIALIZER_ODD_EN
        return (ones % 2) == 0;
`else
        return (ones % 2) == 1;
`endif
    endfunction

    // Line level c cycles after the first start-bit cycle.
    function automatic logic model_tx(input logic [DW-1:0] d, input int c);
        int b;
        b = c / CPB;
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (b == DW + 1) return model_parity(d);
        return 1'b1;
    endfunction

    // Present a word in IDLE; handshake happens on the next rising edge.
    task automatic offer(input logic [DW-1:0] d, input string name);
        @(negedge clk);
        bus.di       = d;
        bus.di_valid = 1'b1;
        checks++;
        if (bus.di_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before_send: got %b expected 1", name, bus.di_ready);
        end
    endtask

    // Check a full frame cycle by cycle, then the IDLE cycle after STOP.
    // next_di/next_valid are driven one cycle into the frame.
    task automatic check_frame(input logic [DW-1:0] d, input logic [DW-1:0] next_di,
                               input logic next_valid, input string name,
                               output int start_cyc);
        start_cyc = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (c == 0) start_cyc = cyc;
            if (c == 1) begin
                bus.di       = next_di;
                bus.di_valid = next_valid;
            end
            checks++;
            if (bus.tx !== model_tx(d, c)) begin
                failures++;
                $display("FAIL %s tx data=%h cycle %0d: got %b expected %b",
                         name, d, c, bus.tx, model_tx(d, c));
            end
            checks++;
            if (bus.busy !== 1'b1 || bus.di_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s busy/ready cycle %0d: got %b/%b expected 1/0",
                         name, c, bus.busy, bus.di_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.di_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_after_stop tx/busy/ready: got %b/%b/%b expected 1/0/1",
                     name, bus.tx, bus.busy, bus.di_ready);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.di       = '0;
        bus.di_valid = 1'b1;  // must be ignored while reset is held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.di_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold tx/busy/ready: got %b/%b/%b expected 1/0/0",
                         bus.tx, bus.busy, bus.di_ready);
            end
        end
        rst          = 1'b0;
        bus.di_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.di_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_idle cycle %0d tx/busy/ready: got %b/%b/%b expected 1/0/1",
                         i, bus.tx, bus.busy, bus.di_ready);
            end
        end
    endtask

    task automatic test_valid_at_release();
        logic [DW-1:0] d;
        int s;
        d = DW'($urandom);
        @(negedge clk);
        rst          = 1'b1;
        bus.di       = d;
        bus.di_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.di_ready !== 1'b0) begin
            failures++;
            $display("FAIL valid_in_reset busy/ready: got %b/%b expected 0/0",
                     bus.busy, bus.di_ready);
        end
        rst = 1'b0;  // first edge after release takes the word
        check_frame(d, DW'($urandom), 1'b0, "valid_at_release", s);
    endtask

    task automatic test_directed();
        int s;
        offer(8'hA5, "frame_a5");
        check_frame(8'hA5, 8'h5A, 1'b0, "frame_a5", s);
        offer(8'h07, "frame_07");
        check_frame(8'h07, 8'hF8, 1'b0, "frame_07", s);
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        offer(8'h00, "b2b_first");
        check_frame(8'h00, 8'hFF, 1'b1, "b2b_first", s1);
        check_frame(8'hFF, 8'h00, 1'b0, "b2b_second", s2);
        checks++;
        if (s2 - s1 !== FRAME + 1) begin
            failures++;
            $display("FAIL b2b_start_spacing: got %0d expected %0d", s2 - s1, FRAME + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s;
        offer(8'h3C, "abort");
        // Run into DATA bit 3 (cycles 16..19 of the frame).
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) bus.di_valid = 1'b0;
            checks++;
            if (bus.tx !== model_tx(8'h3C, c)) begin
                failures++;
                $display("FAIL abort_pre tx cycle %0d: got %b expected %b",
                         c, bus.tx, model_tx(8'h3C, c));
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.di_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_async tx/busy/ready: got %b/%b/%b expected 1/0/0",
                     bus.tx, bus.busy, bus.di_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_dropped cycle %0d tx/busy: got %b/%b expected 1/0",
                         i, bus.tx, bus.busy);
            end
        end
        offer(8'h3C, "abort_resend");
        check_frame(8'h3C, 8'h00, 1'b0, "abort_resend", s);
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        int s;
        for (int n = 0; n < 6; n++) begin
            d = DW'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            offer(d, "random");
            check_frame(d, DW'($urandom), 1'b0, "random", s);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_frame();
        test_valid_at_release();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parity_serializer.md
Name: parity_serializer

Overview:
- Parallel-to-serial framing stage that sits directly downstream of the even-parity generator.
- Accepts a data word over a valid/ready handshake and computes its parity bit.
- Shifts out an asynchronous-serial frame on a single line: start bit, data LSB-first, parity bit, stop bit.
- Each bit is held for a fixed number of clock cycles. Feeds board-level UART/serial links.

Parameters:
- DATA_WIDTH, 8, data bits per frame (>=1).
- CLKS_PER_BIT, 16, clock cycles each serial bit is held (>=2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- di  input  DATA_WIDTH  word to transmit; sampled only on handshake.
- di_valid  input  1  upstream has a word on di.
- di_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).

Behaviour:
- One clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, tx=1, busy=0, di_ready=1 once rst deasserts. di_ready=0 while rst is high. Baud and bit counters are 0.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- di_ready is high only in IDLE; it is a combinational decode of the state register.
- Handshake occurs on a clock edge where di_valid && di_ready.
- On handshake:
  - latch di into the shift register;
  - latch parity(di) into the parity register;
  - enter START with tx=0 from the next cycle.
- di and di_valid are don't-care outside IDLE. Changes to di after the handshake do not affect the frame.
- Baud counter, width $clog2(CLKS_PER_BIT):
  - counts 0..CLKS_PER_BIT-1 in every non-IDLE state;
  - at terminal count, advances the bit or state and reloads 0.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - tx = shift_reg[0];
  - shift right at each bit boundary;
  - bit counter, width $clog2(DATA_WIDTH) (min 1), counts 0..DATA_WIDTH-1;
  - leave DATA after bit DATA_WIDTH-1 completes.
- PARITY: tx = latched parity bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx is driven from a register (no combinational glitches).
- Frame length is (DATA_WIDTH+3)*CLKS_PER_BIT cycles from first tx=0 cycle to end of STOP.
- Back-to-back frames: at least one IDLE cycle after STOP, which always contains the handshake when di_valid is held. Successive start bits are therefore (DATA_WIDTH+3)*CLKS_PER_BIT+1 cycles apart.
- Reset mid-frame: immediate abort. tx=1, busy=0 asynchronously, and the frame is dropped (no partial completion after release).
- di_valid high during reset is not accepted; the first handshake is possible on the first edge after rst deasserts.

Optional Feature:
- Macro PARITY_SERIALIZER_ODD_EN.
- Defined: parity bit is odd parity (inverted generator output), so the total count of ones in data+parity is odd.
- Undefined: even parity; data+parity contains an even number of ones.
- Frame timing is identical in both cases.

Decomposition:
- Shared header/package:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit);
  - counter-width helper constants.
- One sub-module: instantiate the existing parity generator module (DATA_WIDTH passed through) on di. Its output is registered at handshake; no local parity logic.
- FSM, counters and shift register stay in parity_serializer.

Test Plan (DATA_WIDTH=8, CLKS_PER_BIT=4 unless noted):
- Reset: rst=1 at t=0, release -> tx=1, busy=0, di_ready=1. No tx activity for 20 cycles with di_valid=0.
- Send 0xA5:
  - tx = 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each held 4 cycles;
  - busy high 44 cycles; di_ready low throughout the frame.
- Send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1, stop 1.
- Back-to-back, di_valid held with 0x00 then 0xFF:
  - second start bit falls exactly 45 cycles after the first;
  - second parity bit 0;
  - di changed during frame 1 does not corrupt it.
- Reset during DATA bit 3 of 0x3C:
  - tx=1 and busy=0 in the same cycle as the rst rise;
  - after release, a new 0x3C frame is transmitted correctly with parity 0.
- With PARITY_SERIALIZER_ODD_EN defined:
  - 0xA5 -> parity bit 1; 0x07 -> parity bit 0;
  - timing identical to the even-parity case.
